// File: rtl/pwm_sequencer.sv
// Programmable duty sequencer feeding the PWM generator, period-aligned.
// Optional PWM_SEQ_RAMP_EN: duty ramps one LSB per period toward each entry.
module pwm_sequencer #(
  parameter int R = 8,
  parameter int N = 8,
  parameter int HW = 16,
  parameter logic [R-1:0] IDLE_DUTY = '0,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [R-1:0]  wr_duty,
  input  logic [HW-1:0] wr_hold,
  input  logic [AW-1:0] last_idx,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  input  logic          period_tick,
  output logic [R-1:0]  duty,
  output logic          duty_load,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t state, state_d;

  logic [R-1:0]  tbl_duty [N];
  logic [HW-1:0] tbl_hold [N];

  logic [HW-1:0] hold_cnt, hold_d;
  logic [AW-1:0] last_q, last_d, idx_d;
  logic          loop_q, loop_d;
  logic [R-1:0]  duty_d;
  logic          load_d, done_d;
  logic          ld;
  logic [AW-1:0] ld_idx;
  logic [R-1:0]  ld_duty;
  logic [HW-1:0] ld_hold;

`ifdef PWM_SEQ_RAMP_EN
  logic [R-1:0]  tgt_q, tgt_d;
  logic          ramp_q, ramp_d;
  logic [HW-1:0] cur_hold;

  function automatic logic [R-1:0] toward(
    input logic [R-1:0] cur,
    input logic [R-1:0] tgt
  );
    return (cur < tgt) ? cur + R'(1) : cur - R'(1);
  endfunction

  assign cur_hold = (tbl_hold[step_idx] == '0) ?
                    HW'(1) : tbl_hold[step_idx];
`endif

  // Only RUN advances past entry 0; ARM always loads entry 0.
  assign ld_idx  = (state == RUN && step_idx < last_q) ?
                   step_idx + AW'(1) : '0;
  assign ld_duty = tbl_duty[ld_idx];
  assign ld_hold = (tbl_hold[ld_idx] == '0) ?
                   HW'(1) : tbl_hold[ld_idx];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        tbl_duty[i] <= '0;
        tbl_hold[i] <= '0;
      end
    end else if (wr_en && state == IDLE) begin
      tbl_duty[wr_addr] <= wr_duty;
      tbl_hold[wr_addr] <= wr_hold;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      duty      <= IDLE_DUTY;
      duty_load <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      hold_cnt  <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
      tgt_q     <= IDLE_DUTY;
      ramp_q    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      duty      <= duty_d;
      duty_load <= load_d;
      done      <= done_d;
      step_idx  <= idx_d;
      hold_cnt  <= hold_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
`ifdef PWM_SEQ_RAMP_EN
      tgt_q     <= tgt_d;
      ramp_q    <= ramp_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    duty_d  = duty;
    load_d  = 1'b0;
    done_d  = 1'b0;
    idx_d   = step_idx;
    hold_d  = hold_cnt;
    last_d  = last_q;
    loop_d  = loop_q;
    ld      = 1'b0;
`ifdef PWM_SEQ_RAMP_EN
    tgt_d   = tgt_q;
    ramp_d  = ramp_q;
`endif
    unique case (state)
      IDLE: begin
        duty_d = IDLE_DUTY;
        if (start && !stop) begin
          last_d  = last_idx;
          loop_d  = loop_en;
          idx_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (stop) begin
          state_d = IDLE;
          duty_d  = IDLE_DUTY;
        end else if (period_tick) begin
          ld      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          duty_d  = IDLE_DUTY;
`ifdef PWM_SEQ_RAMP_EN
          ramp_d  = 1'b0;
`endif
        end else if (period_tick) begin
`ifdef PWM_SEQ_RAMP_EN
          if (ramp_q) begin
            if (duty != tgt_q) begin
              duty_d = toward(duty, tgt_q);
            end else begin
              hold_d = cur_hold;
              ramp_d = 1'b0;
            end
          end else
`endif
          begin
            if (hold_cnt > HW'(1)) begin
              hold_d = hold_cnt - HW'(1);
            end else if (step_idx < last_q || loop_q) begin
              ld = 1'b1;
            end else begin
              state_d = IDLE;
              duty_d  = IDLE_DUTY;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld) begin
      idx_d  = ld_idx;
      load_d = 1'b1;
`ifdef PWM_SEQ_RAMP_EN
      tgt_d  = ld_duty;
      // Hold starts only once the ramp has reached the target.
      if (duty == ld_duty) begin
        hold_d = ld_hold;
        ramp_d = 1'b0;
      end else begin
        duty_d = toward(duty, ld_duty);
        ramp_d = 1'b1;
      end
`else
      duty_d = ld_duty;
      hold_d = ld_hold;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed self-checking bench for pwm_sequencer (HW=4).
// Ramp scenario runs only when PWM_SEQ_RAMP_EN is defined.
module tb_pwm_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_duty;
  logic [3:0] wr_hold;
  logic [2:0] last_idx;
  logic       loop_en;
  logic       start;
  logic       stop;
  logic       period_tick;
  logic [7:0] duty;
  logic       duty_load;
  logic [2:0] step_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_sequencer #(
    .R(8),
    .N(8),
    .HW(4),
    .IDLE_DUTY(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_duty(wr_duty),
    .wr_hold(wr_hold),
    .last_idx(last_idx),
    .loop_en(loop_en),
    .start(start),
    .stop(stop),
    .period_tick(period_tick),
    .duty(duty),
    .duty_load(duty_load),
    .step_idx(step_idx),
    .busy(busy),
    .done(done)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    period_tick = 1'b1;
    @(posedge clk);
    #1;
    period_tick = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d,
                    input logic [3:0] h);
    wr_en = 1'b1;
    wr_addr = a;
    wr_duty = d;
    wr_hold = h;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [2:0] li, input logic le);
    last_idx = li;
    loop_en = le;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (duty !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_out duty=%h busy=%b done=%b exp 00/0/0",
               duty, busy, done);
    end
    checks++;
    if (step_idx !== 3'd0 || duty_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_idx idx=%0d load=%b exp 0/0",
               step_idx, duty_load);
    end
    go(3'd0, 1'b0);
    checks++;
    if (busy !== 1'b1 || duty !== 8'h00) begin
      errors++;
      $display("FAIL reset_arm busy=%b duty=%h exp 1/00", busy, duty);
    end
    tick();
    checks++;
    if (duty_load !== 1'b1 || duty !== 8'h00) begin
      errors++;
      $display("FAIL blank_load load=%b duty=%h exp 1/00",
               duty_load, duty);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL blank_done done=%b busy=%b exp 1/0", done, busy);
    end
  endtask

  task automatic test_normal();
    logic [7:0] ed [7] = '{8'hBE, 8'hBE, 8'hFF, 8'h88,
                           8'h88, 8'h88, 8'h00};
    logic el [7] = '{1, 0, 1, 1, 0, 0, 0};
    logic [7:0] prev = 8'h00;
    wr(3'd0, 8'hBE, 4'd2);
    wr(3'd1, 8'hFF, 4'd1);
    wr(3'd2, 8'h88, 4'd3);
    go(3'd2, 1'b0);
    checks++;
    if (busy !== 1'b1 || duty !== 8'h00) begin
      errors++;
      $display("FAIL normal_arm busy=%b duty=%h exp 1/00", busy, duty);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(15);
      checks++;
      if (duty !== prev || duty_load !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL normal_between%0d duty=%h load=%b done=%b exp %h/0/0",
                 i, duty, duty_load, done, prev);
      end
      tick();
      checks++;
      if (duty !== ed[i] || duty_load !== el[i] ||
          done !== (i == 6) || busy !== (i < 6)) begin
        errors++;
        $display("FAIL normal_tick%0d duty=%h load=%b done=%b busy=%b exp %h/%b/%b/%b",
                 i, duty, duty_load, done, busy, ed[i], el[i],
                 i == 6, i < 6);
      end
      prev = ed[i];
    end
    cyc(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL normal_done_once done=%b exp 0", done);
    end
  endtask

  task automatic test_loop_stop();
    logic [7:0] ed [7] = '{8'hBE, 8'hBE, 8'hFF, 8'h88,
                           8'h88, 8'h88, 8'hBE};
    logic el [7] = '{1, 0, 1, 1, 0, 0, 1};
    logic [2:0] ei [7] = '{0, 0, 1, 2, 2, 2, 0};
    go(3'd2, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(3);
      tick();
      checks++;
      if (duty !== ed[i] || duty_load !== el[i] || step_idx !== ei[i] ||
          done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL loop_tick%0d duty=%h load=%b idx=%0d done=%b exp %h/%b/%0d/0",
                 i, duty, duty_load, step_idx, done, ed[i], el[i], ei[i]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || duty !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop busy=%b duty=%h done=%b exp 0/00/0",
               busy, duty, done);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop_after busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_hold();
    wr(3'd0, 8'h11, 4'd0);
    wr(3'd1, 8'h22, 4'd15);
    go(3'd1, 1'b0);
    tick();
    checks++;
    if (duty !== 8'h11 || duty_load !== 1'b1) begin
      errors++;
      $display("FAIL hold0_load duty=%h load=%b exp 11/1", duty, duty_load);
    end
    tick();
    checks++;
    if (duty !== 8'h22 || step_idx !== 3'd1 || duty_load !== 1'b1) begin
      errors++;
      $display("FAIL hold0_len duty=%h idx=%0d load=%b exp 22/1/1",
               duty, step_idx, duty_load);
    end
    for (int k = 0; k < 14; k++) begin
      cyc(1);
      tick();
      checks++;
      if (duty !== 8'h22 || busy !== 1'b1 || duty_load !== 1'b0 ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL hold15_tick%0d duty=%h busy=%b load=%b done=%b exp 22/1/0/0",
                 k, duty, busy, duty_load, done);
      end
    end
    tick();
    checks++;
    if (duty !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold15_end duty=%h done=%b busy=%b exp 00/1/0",
               duty, done, busy);
    end
  endtask

  task automatic test_guards();
    wr(3'd0, 8'h40, 4'd1);
    wr(3'd1, 8'h41, 4'd1);
    go(3'd1, 1'b0);
    wr(3'd0, 8'h99, 4'd1);
    go(3'd0, 1'b1);
    checks++;
    if (busy !== 1'b1 || step_idx !== 3'd0 || duty !== 8'h00) begin
      errors++;
      $display("FAIL guard_arm busy=%b idx=%0d duty=%h exp 1/0/00",
               busy, step_idx, duty);
    end
    tick();
    checks++;
    if (duty !== 8'h40) begin
      errors++;
      $display("FAIL guard_e0 duty=%h exp 40", duty);
    end
    wr(3'd1, 8'h77, 4'd1);
    tick();
    checks++;
    if (duty !== 8'h41 || step_idx !== 3'd1) begin
      errors++;
      $display("FAIL guard_e1 duty=%h idx=%0d exp 41/1", duty, step_idx);
    end
    tick();
    checks++;
    if (done !== 1'b1 || duty !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL guard_end done=%b duty=%h busy=%b exp 1/00/0",
               done, duty, busy);
    end
    go(3'd0, 1'b0);
    tick();
    checks++;
    if (duty !== 8'h40) begin
      errors++;
      $display("FAIL guard_table duty=%h exp 40", duty);
    end
    tick();
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL guard_startstop busy=%b exp 0", busy);
    end
    tick();
    checks++;
    if (duty_load !== 1'b0 || duty !== 8'h00) begin
      errors++;
      $display("FAIL guard_idle_tick load=%b duty=%h exp 0/00",
               duty_load, duty);
    end
  endtask

  task automatic test_async_reset();
    go(3'd1, 1'b0);
    tick();
    tick();
    checks++;
    if (duty !== 8'h41 || step_idx !== 3'd1) begin
      errors++;
      $display("FAIL areset_pre duty=%h idx=%0d exp 41/1", duty, step_idx);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (duty !== 8'h00 || busy !== 1'b0 || step_idx !== 3'd0) begin
      errors++;
      $display("FAIL areset_now duty=%h busy=%b idx=%0d exp 00/0/0",
               duty, busy, step_idx);
    end
    #1;
    reset = 1'b1;
    go(3'd1, 1'b0);
    tick();
    checks++;
    if (duty !== 8'h00 || duty_load !== 1'b1) begin
      errors++;
      $display("FAIL areset_e0 duty=%h load=%b exp 00/1", duty, duty_load);
    end
    tick();
    checks++;
    if (duty !== 8'h00 || step_idx !== 3'd1 || duty_load !== 1'b1) begin
      errors++;
      $display("FAIL areset_e1 duty=%h idx=%0d load=%b exp 00/1/1",
               duty, step_idx, duty_load);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL areset_done done=%b exp 1", done);
    end
  endtask

`ifdef PWM_SEQ_RAMP_EN
  task automatic test_ramp();
    logic [7:0] ed [10] = '{1, 2, 3, 4, 4, 4, 3, 2, 2, 0};
    logic el [10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    wr(3'd0, 8'd4, 4'd2);
    wr(3'd1, 8'd2, 4'd1);
    go(3'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(2);
      tick();
      checks++;
      if (duty !== ed[i] || duty_load !== el[i] || done !== (i == 9)) begin
        errors++;
        $display("FAIL ramp_tick%0d duty=%0d load=%b done=%b exp %0d/%b/%b",
                 i, duty, duty_load, done, ed[i], el[i], i == 9);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_duty = '0;
    wr_hold = '0;
    last_idx = '0;
    loop_en = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    period_tick = 1'b0;
    #12;
    reset = 1'b1;
    cyc(1);
    test_reset();
`ifdef PWM_SEQ_RAMP_EN
    test_ramp();
`else
    test_normal();
    test_loop_stop();
    test_hold();
    test_guards();
    test_async_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
